// File: rtl/logic_gate_pkg.sv
// Shared opcodes and the bitwise fold used by logic_gate_pipe.
// gate_eval works on a fixed maximum operand layout so callers of any size can share it.
package logic_gate_pkg;
  localparam int OP_W   = 3;
  localparam int MAX_W  = 32;
  localparam int MAX_IN = 8;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_XNOR;
  endfunction

  // Operand i sits at data[i*MAX_W +: MAX_W]; inversion applies once, after the fold.
  function automatic logic [MAX_W-1:0] gate_eval(input logic [OP_W-1:0] op,
                                                 input logic [MAX_IN*MAX_W-1:0] data,
                                                 input int num_in,
                                                 input int width);
    logic [MAX_W-1:0] acc;
    logic [MAX_W-1:0] mask;
    acc = data[MAX_W-1:0];
    for (int i = 1; i < MAX_IN; i++) begin
      if (i < num_in) begin
        case (op)
          OP_AND, OP_NAND: acc = acc & data[i*MAX_W +: MAX_W];
          OP_OR,  OP_NOR:  acc = acc | data[i*MAX_W +: MAX_W];
          OP_XOR, OP_XNOR: acc = acc ^ data[i*MAX_W +: MAX_W];
          default: ;
        endcase
      end
    end
    if (op == OP_NAND || op == OP_NOR || op == OP_XNOR) acc = ~acc;
    if (!op_legal(op)) acc = '0;
    mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
    return acc & mask;
  endfunction
endpackage

// File: rtl/logic_gate_fifo2.sv
// Two-entry synchronous FIFO; entry 0 is always the head, unused slots are held at zero.
module logic_gate_fifo2
  import logic_gate_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);
  logic [DW-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]    cnt_q, cnt_d, occ;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok = push && (cnt_q != 2'd2);
    pop_ok  = pop && (cnt_q != 2'd0);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    if (pop_ok) begin
      mem0_d = mem1_q;
      mem1_d = '0;
    end
    // Push lands in the first free slot after any pop on the same edge.
    occ = cnt_q - {1'b0, pop_ok};
    if (push_ok) begin
      if (occ == 2'd0) mem0_d = din;
      else             mem1_d = din;
    end
    cnt_d = occ + {1'b0, push_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = mem0_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;
endmodule

// File: rtl/logic_gate_pipe.sv
// Selectable N-operand bitwise gate with a registered 2-deep output buffer,
// a saturating accept counter and a sticky illegal-opcode flag.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_y,
  output logic [OP_W-1:0]         out_op,
  output logic                    out_any,
  output logic [CNT_W-1:0]        txn_count,
  output logic                    err_op
);
  localparam int DW = WIDTH + OP_W;

  logic [MAX_IN*MAX_W-1:0] ops_wide;
  logic [WIDTH-1:0]        y_eval;
  logic [DW-1:0]           head;
  logic                    fifo_full, fifo_empty, accept;
  logic [1:0]              fifo_count;
  logic [CNT_W-1:0]        txn_q, txn_d;
  logic                    err_q, err_d;

  always_comb begin
    ops_wide = '0;
    for (int i = 0; i < NUM_IN; i++)
      ops_wide[i*MAX_W +: MAX_W] = MAX_W'(in_data[i*WIDTH +: WIDTH]);
    y_eval = WIDTH'(gate_eval(in_op, ops_wide, NUM_IN, WIDTH));
  end

  // Handshake status comes straight from the registered occupancy.
  assign in_ready  = (fifo_count != 2'd2);
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;

  logic_gate_fifo2 #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && !fifo_full),
    .pop   (out_ready),
    .din   ({y_eval, in_op}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    txn_d = txn_q;
    if (accept && (txn_q != {CNT_W{1'b1}})) txn_d = txn_q + CNT_W'(1);
    err_d = err_q | (accept && !op_legal(in_op));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q <= '0;
      err_q <= 1'b0;
    end else begin
      txn_q <= txn_d;
      err_q <= err_d;
    end
  end

  assign out_y     = head[DW-1:OP_W];
  assign out_op    = head[OP_W-1:0];
  assign out_any   = |out_y;
  assign txn_count = txn_q;
  assign err_op    = err_q;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomised and directed bench for logic_gate_pipe against a queue-based reference model.
module tb_logic_gate_pipe;
  localparam int W = 4;
  localparam int N = 3;
  localparam logic [11:0] D = 12'h953;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [2:0] in_op;
  logic in_ready, out_valid, out_any, err_op;
  logic [W-1:0] out_y;
  logic [2:0] out_op;
  logic [15:0] txn_count;
  logic s_in_ready, s_out_valid, s_out_any, s_err_op;
  logic [W-1:0] s_out_y;
  logic [2:0] s_out_op;
  logic [2:0] s_txn_count;

  typedef struct packed { logic [W-1:0] y; logic [2:0] op; } ent_t;
  ent_t mq[$];
  int m_txn, m_txn_sat;
  logic m_err;
  int n_tests, n_fail;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_op(out_op), .out_any(out_any), .txn_count(txn_count), .err_op(err_op));

  logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_op(in_op), .out_valid(s_out_valid), .out_ready(out_ready), .out_y(s_out_y),
    .out_op(s_out_op), .out_any(s_out_any), .txn_count(s_txn_count), .err_op(s_err_op));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_eval(input logic [2:0] op, input logic [11:0] d);
    logic [W-1:0] a0, a1, a2;
    a0 = d[3:0]; a1 = d[7:4]; a2 = d[11:8];
    case (op)
      3'd0: return a0 & a1 & a2;
      3'd1: return a0 | a1 | a2;
      3'd2: return a0 ^ a1 ^ a2;
      3'd3: return ~(a0 & a1 & a2);
      3'd4: return ~(a0 | a1 | a2);
      3'd5: return ~(a0 ^ a1 ^ a2);
      default: return '0;
    endcase
  endfunction

  task automatic check_state();
    check_eq("out_valid", out_valid, mq.size() > 0);
    check_eq("in_ready", in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      check_eq("out_y", out_y, mq[0].y);
      check_eq("out_op", out_op, mq[0].op);
      check_eq("out_any", out_any, |mq[0].y);
    end
    check_eq("txn_count", txn_count, m_txn);
    check_eq("err_op", err_op, m_err);
    check_eq("sat_txn_count", s_txn_count, m_txn_sat);
    check_eq("sat_out_valid", s_out_valid, mq.size() > 0);
  endtask

  task automatic cycle(input logic v, input logic [2:0] op, input logic [11:0] d,
                       input logic rdy, input logic r);
    logic acc, xfer;
    rst = r; in_valid = v; in_op = op; in_data = d; out_ready = rdy;
    acc  = v && (mq.size() < 2);
    xfer = rdy && (mq.size() > 0);
    @(posedge clk);
    if (r) begin
      mq.delete(); m_txn = 0; m_txn_sat = 0; m_err = 1'b0;
    end else begin
      if (xfer) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{y: ref_eval(op, d), op: op});
        if (m_txn < 65535) m_txn++;
        if (m_txn_sat < 7) m_txn_sat++;
        if (op > 3'd5) m_err = 1'b1;
      end
    end
    #1;
    check_state();
  endtask

  initial begin
    logic [W-1:0] exp_y [6];
    exp_y = '{4'h1, 4'hF, 4'hF, 4'hE, 4'h0, 4'h0};
    n_tests = 0; n_fail = 0; m_txn = 0; m_txn_sat = 0; m_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; out_ready = 1'b0;

    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, D, 1, 1);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_out_op", out_op, 0);
    check_eq("rst_out_any", out_any, 0);

    for (int op = 0; op < 6; op++) begin
      cycle(1, 3'(op), D, 1, 0);
      check_eq("single_y", out_y, exp_y[op]);
      check_eq("single_valid", out_valid, 1);
      cycle(0, 0, 0, 1, 0);
    end
    check_eq("single_txn", txn_count, 6);

    cycle(1, 3'd1, D, 0, 0);
    cycle(1, 3'd0, D, 0, 0);
    check_eq("bp_in_ready_low", in_ready, 0);
    cycle(1, 3'd2, D, 0, 0);
    check_eq("bp_third_ignored", txn_count, 8);
    check_eq("bp_head_or", out_y, 4'hF);
    cycle(0, 0, 0, 1, 0);
    check_eq("bp_second_and", out_y, 4'h1);
    check_eq("bp_in_ready_back", in_ready, 1);
    cycle(0, 0, 0, 1, 0);

    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 3'($urandom_range(5)), 12'($urandom), 1, 0);
      check_eq("stream_valid", out_valid, 1);
    end
    check_eq("stream_txn", txn_count, 8);
    cycle(0, 0, 0, 1, 0);

    cycle(1, 3'd6, D, 1, 0);
    check_eq("ill_y", out_y, 0);
    check_eq("ill_op", out_op, 6);
    check_eq("ill_err", err_op, 1);
    cycle(1, 3'd1, D, 1, 0);
    cycle(1, 3'd2, D, 1, 0);
    check_eq("ill_err_sticky", err_op, 1);

    cycle(1, 3'd7, D, 0, 0);
    cycle(1, 3'd0, D, 0, 0);
    cycle(1, 3'd4, D, 1, 1);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_txn", txn_count, 0);
    check_eq("mid_rst_err", err_op, 0);
    cycle(1, 3'd1, D, 1, 0);
    check_eq("post_rst_or", out_y, 4'hF);
    cycle(0, 0, 0, 1, 0);

    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 3'd1, 12'($urandom), 1, 0);
    check_eq("sat_txn", s_txn_count, 7);
    check_eq("nosat_txn", txn_count, 10);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, 3'($urandom_range(7)), 12'($urandom),
            $urandom_range(1) == 1, $urandom_range(39) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
